alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 26 ++
 rtl/alu_mc_iter.sv | 76 +++++++
 rtl/alu_mc.sv | 144 ++++++++++++++
 tb/tb_alu_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM encoding and default width for the multi-cycle ALU.
// Imported by alu_mc and alu_mc_iter.
package alu_mc_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_ADC = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_SBB = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05;
  localparam logic [7:0] OP_XOR = 8'h06;
  localparam logic [7:0] OP_NOT = 8'h07;
  localparam logic [7:0] OP_SHL = 8'h08;
  localparam logic [7:0] OP_SHR = 8'h09;
  localparam logic [7:0] OP_MUL = 8'h0A;
  localparam logic [7:0] OP_DIV = 8'h0B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider.
// Ports: start loads operands (a, b); step advances one bit; last marks the
// final step; hi_next/lo_next are the register values after this step.
import alu_mc_pkg::*;

module alu_mc_iter #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int CW = $clog2(WIDTH + 1);

  // hi: partial product / remainder; lo: multiplier / quotient
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH:0]   sum, rsh, diff;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, m_q};
    rsh     = {hi_q, lo_q[WIDTH-1]};
    diff    = rsh - {1'b0, m_q};
    hi_next = hi_q;
    lo_next = lo_q;
    if (div_q) begin
      // negative trial difference means restore
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rsh[WIDTH-1:0];
        lo_next = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {hi_next, lo_next} = {sum, lo_q[WIDTH-1:1]};
    end else begin
      {hi_next, lo_next} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (enable) begin
      if (start) begin
        hi_q  <= '0;
        lo_q  <= div ? a : b;
        m_q   <= div ? b : a;
        cnt_q <= '0;
        div_q <= div;
      end else if (step) begin
        hi_q  <= hi_next;
        lo_q  <= lo_next;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arith/logic ops, iterative MUL/DIV.
// Ports: valid/ready request (operation, op1, op2, cpu_carry) and
// valid/ready result (result_l, result_h, carry, zero, sign, illegal).
import alu_mc_pkg::*;

module alu_mc #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       operation,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cpu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_l,
  output logic [WIDTH-1:0] result_h,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic             accept, iter_op, last;
  logic [7:0]       opc_q;
  logic             dz_q;
  logic [WIDTH-1:0] sc_l, hi_n, lo_n;
  logic             sc_c, sc_ill;
  logic [WIDTH:0]   sum, dif;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign accept    = in_valid & in_ready & enable;
  assign iter_op   = (operation == OP_MUL) |
                     (operation == OP_DIV);

  always_comb begin
    sum = {1'b0, op1} + {1'b0, op2} +
          (WIDTH+1)'(cpu_carry & (operation == OP_ADC));
    dif = {1'b0, op1} - {1'b0, op2} -
          (WIDTH+1)'(cpu_carry & (operation == OP_SBB));
    sc_l   = '0;
    sc_c   = 1'b0;
    sc_ill = 1'b0;
    case (operation)
      OP_ADD, OP_ADC: {sc_c, sc_l} = sum;
      OP_SUB, OP_SBB: {sc_c, sc_l} = dif;
      OP_AND: sc_l = op1 & op2;
      OP_OR:  sc_l = op1 | op2;
      OP_XOR: sc_l = op1 ^ op2;
      OP_NOT: sc_l = ~op1;
      OP_SHL: begin
        sc_l = {op1[WIDTH-2:0], 1'b0};
        sc_c = op1[WIDTH-1];
      end
      OP_SHR: begin
        sc_l = {1'b0, op1[WIDTH-1:1]};
        sc_c = op1[0];
      end
      OP_MUL, OP_DIV: sc_l = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      opc_q <= operation;
      dz_q  <= (op2 == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = iter_op ? S_ITER : S_OUT;
      S_ITER:
        if (enable && last) state_d = S_OUT;
      S_OUT:
        if (enable && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_l <= '0;
      result_h <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      sign     <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !iter_op) begin
      result_l <= sc_l;
      result_h <= '0;
      carry    <= sc_c;
      zero     <= (sc_l == '0);
      sign     <= sc_l[WIDTH-1];
      illegal  <= sc_ill;
    end else if (enable && state_q == S_ITER && last) begin
      result_l <= lo_n;
      result_h <= hi_n;
      illegal  <= 1'b0;
      if (opc_q == OP_MUL) begin
        carry <= (hi_n != '0);
        zero  <= (hi_n == '0) && (lo_n == '0);
        sign  <= hi_n[WIDTH-1];
      end else begin
        carry <= dz_q;
        zero  <= (lo_n == '0);
        sign  <= lo_n[WIDTH-1];
      end
    end
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .start   (accept && iter_op),
    .div     (operation == OP_DIV),
    .step    (state_q == S_ITER),
    .a       (op1),
    .b       (op2),
    .last    (last),
    .hi_next (hi_n),
    .lo_next (lo_n)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed table, hand sequences
// and randomized operations against a behavioural model.
module tb_alu_mc;

  localparam int W = 8;

  logic         clk, rst, enable, in_valid, in_ready;
  logic [7:0]   operation;
  logic [W-1:0] op1, op2, result_l, result_h;
  logic         cpu_carry, out_valid, out_ready;
  logic         carry, zero, sign, illegal;

  int vecs = 0;
  int errs = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .op1       (op1),
    .op2       (op2),
    .cpu_carry (cpu_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_l  (result_l),
    .result_h  (result_h),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         gs;
    int         gl;
    int         hold;
    logic [7:0] l;
    logic [7:0] h;
    logic       c;
    logic       z;
    logic       s;
    logic       ill;
    int         lat;
  } vec_t;

  // Behavioural reference from the opcode definitions
  task automatic model(input logic [7:0] opc, a, b, input logic cin,
                       output logic [7:0] l, h,
                       output logic c, z, s, ill);
    longint x;
    longint ai, bi;
    ai = longint'(a);
    bi = longint'(b);
    x = 0;
    l = 0; h = 0; c = 0; ill = 0;
    case (opc)
      8'h00: begin x = ai + bi; l = 8'(x % 256); c = x > 255; end
      8'h01: begin x = ai + bi + cin; l = 8'(x % 256); c = x > 255; end
      8'h02: begin x = ai - bi + 256; l = 8'(x % 256); c = ai < bi; end
      8'h03: begin
        x = ai - bi - cin + 512; l = 8'(x % 256); c = ai < bi + cin;
      end
      8'h04: l = a & b;
      8'h05: l = a | b;
      8'h06: l = a ^ b;
      8'h07: l = ~a;
      8'h08: begin l = 8'((ai * 2) % 256); c = ai >= 128; end
      8'h09: begin l = 8'(ai / 2); c = (ai % 2) == 1; end
      8'h0A: begin
        x = ai * bi; l = 8'(x % 256); h = 8'(x / 256); c = h != 0;
      end
      8'h0B: begin
        if (bi == 0) begin l = 8'hFF; h = a; c = 1; end
        else begin l = 8'(ai / bi); h = 8'(ai % bi); end
      end
      default: ill = 1;
    endcase
    z = (opc == 8'h0A) ? (x == 0) : (l == 0);
    s = (opc == 8'h0A) ? h[7] : l[7];
  endtask

  // Issue one request; enable is dropped on accept-relative edges
  // gs..gs+gl-1 (accept edge = 1); result held for `hold` stalled cycles.
  task automatic do_op(input logic [7:0] opc, a, b, input logic cin,
                       input int gs, gl, hold,
                       output logic [7:0] l, h,
                       output logic c, z, s, ill, output int lat);
    bit done;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready: in_ready=%b want 1", in_ready);
    end
    operation = opc; op1 = a; op2 = b; cpu_carry = cin;
    in_valid = 1'b1; enable = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    done = 0;
    while (!done && lat < 64) begin
      @(negedge clk);
      if (lat == 1) begin
        in_valid = 1'b0;
        operation = 8'($urandom); op1 = 8'($urandom);
        op2 = 8'($urandom); cpu_carry = 1'($urandom);
      end
      if (out_valid === 1'b1) done = 1;
      else begin
        enable = !((lat + 1) >= gs && (lat + 1) < gs + gl);
        @(posedge clk);
        lat++;
      end
    end
    enable = 1'b1;
    l = result_l; h = result_h; c = carry; z = zero; s = sign; ill = illegal;
    if (!done) begin
      vecs++; errs++;
      $display("FAIL timeout: out_valid=%b after %0d cycles want 1",
               out_valid, lat);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      vecs++;
      if (out_valid !== 1 || in_ready !== 0 || result_l !== l ||
          result_h !== h || carry !== c || zero !== z || sign !== s ||
          illegal !== ill) begin
        errs++;
        $display("FAIL stall%0d: ov=%b ir=%b l=%h h=%h want ov=1 ir=0 l=%h h=%h",
                 k, out_valid, in_ready, result_l, result_h, l, h);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic check(input string nm, input logic [7:0] l, h,
                       input logic c, z, s, ill, input int lat,
                       input logic [7:0] el, eh,
                       input logic ec, ez, es, eill, input int elat);
    vecs++;
    if (l !== el || h !== eh || c !== ec || z !== ez || s !== es ||
        ill !== eill || lat != elat) begin
      errs++;
      $display("FAIL %s: got l=%h h=%h c=%b z=%b s=%b ill=%b lat=%0d want l=%h h=%h c=%b z=%b s=%b ill=%b lat=%0d",
               nm, l, h, c, z, s, ill, lat, el, eh, ec, ez, es, eill, elat);
    end
  endtask

  task automatic check_idle(input string nm);
    vecs++;
    if (in_ready !== 1 || out_valid !== 0 || result_l !== 0 ||
        result_h !== 0 || carry !== 0 || zero !== 0 || sign !== 0 ||
        illegal !== 0) begin
      errs++;
      $display("FAIL %s: ir=%b ov=%b l=%h h=%h c=%b z=%b s=%b ill=%b want ir=1 rest 0",
               nm, in_ready, out_valid, result_l, result_h,
               carry, zero, sign, illegal);
    end
  endtask

  vec_t tbl[14];

  initial begin
    logic [7:0] l, h, el, eh, opc, a, b;
    logic c, z, s, ill, ec, ez, es, eill, cin;
    int lat, gs, gl, hold, elat;

    tbl[0]  = '{8'h00, 8'hFF, 8'h01, 1'b0, 0, 0, 0,
                8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{8'h0A, 8'hFF, 8'hFF, 1'b0, 0, 0, 0,
                8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 9};
    tbl[2]  = '{8'h0B, 8'h64, 8'h07, 1'b0, 5, 3, 0,
                8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 12};
    tbl[3]  = '{8'h0B, 8'h64, 8'h00, 1'b0, 0, 0, 0,
                8'hFF, 8'h64, 1'b1, 1'b0, 1'b1, 1'b0, 9};
    tbl[4]  = '{8'h03, 8'h10, 8'h10, 1'b1, 0, 0, 5,
                8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[5]  = '{8'h3C, 8'h55, 8'hAA, 1'b0, 0, 0, 0,
                8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[6]  = '{8'h00, 8'h12, 8'h34, 1'b0, 0, 0, 0,
                8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{8'h08, 8'h81, 8'h00, 1'b0, 0, 0, 0,
                8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{8'h09, 8'h81, 8'h00, 1'b0, 0, 0, 0,
                8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{8'h07, 8'h0F, 8'h00, 1'b0, 0, 0, 0,
                8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{8'h01, 8'h7F, 8'h00, 1'b1, 0, 0, 0,
                8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[11] = '{8'h02, 8'h05, 8'h07, 1'b0, 0, 0, 0,
                8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[12] = '{8'h0A, 8'h10, 8'h10, 1'b0, 0, 0, 0,
                8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 9};
    tbl[13] = '{8'h06, 8'hAA, 8'hAA, 1'b0, 0, 0, 0,
                8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};

    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operation = 8'h00; op1 = '0; op2 = '0; cpu_carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    check_idle("reset");

    foreach (tbl[i]) begin
      do_op(tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].cin,
            tbl[i].gs, tbl[i].gl, tbl[i].hold,
            l, h, c, z, s, ill, lat);
      check($sformatf("tbl%0d", i), l, h, c, z, s, ill, lat,
            tbl[i].l, tbl[i].h, tbl[i].c, tbl[i].z, tbl[i].s,
            tbl[i].ill, tbl[i].lat);
    end

    // reset in the middle of a multiply discards it
    @(negedge clk);
    operation = 8'h0A; op1 = 8'hFF; op2 = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid_mul");
    repeat (12) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL rst_discard: out_valid=%b want 0", out_valid);
      end
    end

    for (int n = 0; n < 200; n++) begin
      opc = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) opc = 8'($urandom_range(12, 255));
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      cin = 1'($urandom);
      gs = $urandom_range(2, W + 1);
      gl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      hold = $urandom_range(0, 2);
      model(opc, a, b, cin, el, eh, ec, ez, es, eill);
      elat = (opc == 8'h0A || opc == 8'h0B) ? W + 1 + gl : 1;
      do_op(opc, a, b, cin, gs, gl, hold, l, h, c, z, s, ill, lat);
      check($sformatf("rnd%0d op%h %h,%h", n, opc, a, b),
            l, h, c, z, s, ill, lat, el, eh, ec, ez, es, eill, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
